// File: rtl/rc4_pkg.sv
// rc4_pkg: shared types and constants for the RC4 PRGA/decrypt stage (loop_3).
//   byte_t         - 8-bit data/address byte
//   prga_state_e   - PRGA controller state encoding
//   *_DEFAULT      - default message length and memory read latency
//   ASCII_*        - accepted plaintext alphabet (lowercase letters and space)
//   is_plain_char  - true when a decrypted byte lies in the accepted alphabet
package rc4_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [3:0] {
    StIdle,
    StIncI,
    StReadSi,
    StWaitSi,
    StSaveSi,
    StReadSj,
    StWaitSj,
    StSaveSj,
    StWriteI,
    StWriteJ,
    StReadF,
    StWaitF,
    StSaveF,
    StWritePt,
    StDone
  } prga_state_e;

  localparam int unsigned MSG_LEN_DEFAULT = 32;
  localparam int unsigned RD_LAT_DEFAULT  = 2;

  localparam byte_t ASCII_LO = 8'h61;
  localparam byte_t ASCII_HI = 8'h7A;
  localparam byte_t ASCII_SP = 8'h20;

  function automatic logic is_plain_char(byte_t b);
    return ((b >= ASCII_LO) && (b <= ASCII_HI)) || (b == ASCII_SP);
  endfunction

endpackage

// File: rtl/loop_3_mem_read_wait.sv
// mem_read_wait: RD_LAT-deep countdown shared by every memory read phase of loop_3.
// The caller holds the read address stable while this counter runs; rd_valid marks the
// last wait cycle, so the following state can latch the read data.
//   clk      - system clock
//   rst      - synchronous active-high reset
//   en       - count enable; low freezes the countdown
//   start    - pulse in the cycle the read address is first issued
//   rd_valid - high in the final wait cycle (read data valid from the next cycle on)
// RD_LAT must be at least 1.
module mem_read_wait #(
  parameter int unsigned RD_LAT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic start,
  output logic rd_valid
);

  localparam int unsigned CntW = $clog2(RD_LAT + 1);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (en) begin
      if (start) begin
        cnt_q <= CntW'(RD_LAT);
      end else if (cnt_q != '0) begin
        cnt_q <= cnt_q - CntW'(1);
      end
    end
  end

  assign rd_valid = en && (cnt_q == CntW'(1));

endmodule

// File: rtl/loop_3.sv
// loop_3: RC4 PRGA/decrypt stage. Continues the i/j swaps on the S array left by the KSA
// stage, generates one keystream byte per message byte, XORs it with the ciphertext ROM
// and writes the plaintext RAM. done_flag is sticky until rst.
//   clk, rst           - system clock, synchronous active-high reset
//   second_loop_done   - level start from the KSA stage; low freezes the controller
//   done_flag          - all bytes written (or key rejected); sticky
//   s_addr/s_rddata/s_wrdata/s_wren - S RAM port
//   ct_addr/ct_rddata  - ciphertext ROM port (address = byte index k)
//   pt_addr/pt_wrdata/pt_wren       - plaintext RAM port
//   key_invalid        - only with PLAINTEXT_CHECK_EN: a decrypted byte fell outside
//                        lowercase/space, the write was dropped and the run ended
// Optional feature macro: PLAINTEXT_CHECK_EN.
// Every attached memory has RD_LAT cycles of read latency; each read holds its address
// from READ through SAVE so data is stable when latched.
module loop_3
  import rc4_pkg::*;
#(
  parameter int unsigned MSG_LEN = MSG_LEN_DEFAULT,
  parameter int unsigned RD_LAT  = RD_LAT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       second_loop_done,
  output logic       done_flag,
  output logic [7:0] s_addr,
  input  logic [7:0] s_rddata,
  output logic [7:0] s_wrdata,
  output logic       s_wren,
  output logic [4:0] ct_addr,
  input  logic [7:0] ct_rddata,
  output logic [4:0] pt_addr,
  output logic [7:0] pt_wrdata,
  output logic       pt_wren
`ifdef PLAINTEXT_CHECK_EN
  ,
  output logic       key_invalid
`endif
);

  prga_state_e state_q, state_d;

  byte_t      i_q, j_q, si_q, sj_q, f_q, ct_q;
  logic [8:0] k_q;
  byte_t      pt_byte;
  logic       run;
  logic       rd_start;
  logic       rd_valid;
  logic       last_byte;
  logic       pt_ok;

  assign run       = second_loop_done;
  assign pt_byte   = f_q ^ ct_q;
  assign last_byte = (k_q == 9'(MSG_LEN - 1));

`ifdef PLAINTEXT_CHECK_EN
  assign pt_ok = is_plain_char(pt_byte);
`else
  assign pt_ok = 1'b1;
`endif

  assign rd_start = run && ((state_q == StReadSi) || (state_q == StReadSj) ||
                            (state_q == StReadF));

  mem_read_wait #(
    .RD_LAT(RD_LAT)
  ) u_rd_wait (
    .clk     (clk),
    .rst     (rst),
    .en      (run),
    .start   (rd_start),
    .rd_valid(rd_valid)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state; the whole controller freezes while the start level is low.
  always_comb begin
    state_d = state_q;
    if (run) begin
      unique case (state_q)
        StIdle:    state_d = StIncI;
        StIncI:    state_d = StReadSi;
        StReadSi:  state_d = StWaitSi;
        StWaitSi:  if (rd_valid) state_d = StSaveSi;
        StSaveSi:  state_d = StReadSj;
        StReadSj:  state_d = StWaitSj;
        StWaitSj:  if (rd_valid) state_d = StSaveSj;
        StSaveSj:  state_d = StWriteI;
        StWriteI:  state_d = StWriteJ;
        StWriteJ:  state_d = StReadF;
        StReadF:   state_d = StWaitF;
        StWaitF:   if (rd_valid) state_d = StSaveF;
        StSaveF:   state_d = StWritePt;
        StWritePt: state_d = (!pt_ok || last_byte) ? StDone : StIncI;
        StDone:    state_d = StDone;
        default:   state_d = StIdle;
      endcase
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      i_q  <= '0;
      j_q  <= '0;
      k_q  <= '0;
      si_q <= '0;
      sj_q <= '0;
      f_q  <= '0;
      ct_q <= '0;
`ifdef PLAINTEXT_CHECK_EN
      key_invalid <= 1'b0;
`endif
    end else if (run) begin
      case (state_q)
        StIncI: i_q <= i_q + 8'd1;
        StSaveSi: begin
          si_q <= s_rddata;
          j_q  <= j_q + s_rddata;
        end
        StSaveSj: sj_q <= s_rddata;
        StSaveF: begin
          f_q  <= s_rddata;
          ct_q <= ct_rddata;
        end
        StWritePt: begin
          k_q <= k_q + 9'd1;
`ifdef PLAINTEXT_CHECK_EN
          if (!pt_ok) key_invalid <= 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

  // Outputs. Addresses are held across READ/WAIT/SAVE; enables only in write states.
  always_comb begin
    s_addr    = '0;
    s_wrdata  = '0;
    s_wren    = 1'b0;
    ct_addr   = '0;
    pt_addr   = '0;
    pt_wrdata = '0;
    pt_wren   = 1'b0;
    done_flag = 1'b0;
    case (state_q)
      StReadSi, StWaitSi, StSaveSi: s_addr = i_q;
      StReadSj, StWaitSj, StSaveSj: s_addr = j_q;
      StWriteI: begin
        s_addr   = i_q;
        s_wrdata = sj_q;
        s_wren   = run;
      end
      StWriteJ: begin
        s_addr   = j_q;
        s_wrdata = si_q;
        s_wren   = run;
      end
      StReadF, StWaitF, StSaveF: begin
        s_addr  = si_q + sj_q;
        ct_addr = k_q[4:0];
      end
      StWritePt: begin
        pt_addr   = k_q[4:0];
        pt_wrdata = pt_byte;
        pt_wren   = run && pt_ok;
      end
      StDone: done_flag = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_loop_3.sv
// Directed bench for loop_3: identity S array, hand-computed plaintext bytes, an RC4
// reference model for full-message comparison, mid-run reset and start-drop cases, and
// a MSG_LEN=1 instance.
module tb_loop_3;
  import rc4_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic sld = 1'b0;
  logic sld1 = 1'b0;
  logic init_s = 1'b0;
  logic clr_mon = 1'b0;

  int total = 0;
  int bad = 0;

  // DUT0 (MSG_LEN=32)
  logic       done_flag, s_wren, pt_wren;
  logic [7:0] s_addr, s_rddata, s_wrdata, ct_rddata, pt_wrdata;
  logic [4:0] ct_addr, pt_addr;
  // DUT1 (MSG_LEN=1)
  logic       done1, s_wren1, pt_wren1;
  logic [7:0] s_addr1, s_rddata1, s_wrdata1, pt_wrdata1;
  logic [4:0] ct_addr1, pt_addr1;
`ifdef PLAINTEXT_CHECK_EN
  logic       key_invalid, key_invalid1;
`endif

  loop_3 #(.MSG_LEN(32), .RD_LAT(2)) dut (
    .clk(clk), .rst(rst), .second_loop_done(sld), .done_flag(done_flag),
    .s_addr(s_addr), .s_rddata(s_rddata), .s_wrdata(s_wrdata), .s_wren(s_wren),
    .ct_addr(ct_addr), .ct_rddata(ct_rddata),
    .pt_addr(pt_addr), .pt_wrdata(pt_wrdata), .pt_wren(pt_wren)
`ifdef PLAINTEXT_CHECK_EN
    , .key_invalid(key_invalid)
`endif
  );

  loop_3 #(.MSG_LEN(1), .RD_LAT(2)) dut1 (
    .clk(clk), .rst(rst), .second_loop_done(sld1), .done_flag(done1),
    .s_addr(s_addr1), .s_rddata(s_rddata1), .s_wrdata(s_wrdata1), .s_wren(s_wren1),
    .ct_addr(ct_addr1), .ct_rddata(8'h00),
    .pt_addr(pt_addr1), .pt_wrdata(pt_wrdata1), .pt_wren(pt_wren1)
`ifdef PLAINTEXT_CHECK_EN
    , .key_invalid(key_invalid1)
`endif
  );

  // Memory models: RD_LAT=2 read pipeline, write on clock edge.
  byte_t s_mem[256];
  byte_t ct_mem[32];
  byte_t pt_mem[32];
  byte_t s_p0, s_p1, ct_p0, ct_p1, cap2, cap3;
  int    pt_cnt, gap_wr;
  byte_t s_mem1[256];
  byte_t s1_p0, s1_p1, pt_last1;
  logic [4:0] pt_addr_last1;
  int    pt_cnt1;
  byte_t exp_pt[32];

  assign s_rddata  = s_p1;
  assign ct_rddata = ct_p1;
  assign s_rddata1 = s1_p1;

  always @(posedge clk) begin
    s_p0  <= s_mem[s_addr];
    s_p1  <= s_p0;
    ct_p0 <= ct_mem[ct_addr];
    ct_p1 <= ct_p0;
    s1_p0 <= s_mem1[s_addr1];
    s1_p1 <= s1_p0;
    if (init_s) begin
      for (int x = 0; x < 256; x++) begin
        s_mem[x]  <= byte_t'(x);
        s_mem1[x] <= byte_t'(x);
      end
    end else begin
      if (s_wren)  s_mem[s_addr]   <= s_wrdata;
      if (s_wren1) s_mem1[s_addr1] <= s_wrdata1;
    end
    if (clr_mon) begin
      pt_cnt  <= 0;
      gap_wr  <= 0;
      pt_cnt1 <= 0;
      for (int x = 0; x < 32; x++) pt_mem[x] <= 8'h00;
    end else begin
      if (pt_wren) begin
        pt_mem[pt_addr] <= pt_wrdata;
        pt_cnt <= pt_cnt + 1;
        if (pt_addr == 5'd1) begin
          cap2 <= s_mem[2];
          cap3 <= s_mem[3];
        end
      end
      if (!sld && (s_wren || pt_wren)) gap_wr <= gap_wr + 1;
      if (pt_wren1) begin
        pt_cnt1       <= pt_cnt1 + 1;
        pt_last1      <= pt_wrdata1;
        pt_addr_last1 <= pt_addr1;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
    end
  endtask

  // Reference RC4 PRGA from identity S over the current ct_mem.
  task automatic model_run();
    byte_t s[256];
    byte_t i, j, t, idx;
    for (int x = 0; x < 256; x++) s[x] = byte_t'(x);
    i = 0;
    j = 0;
    for (int n = 0; n < 32; n++) begin
      i = i + 8'd1;
      j = j + s[i];
      t = s[i];
      s[i] = s[j];
      s[j] = t;
      idx = s[i] + s[j];
      exp_pt[n] = s[idx] ^ ct_mem[n];
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    sld = 1'b0;
    sld1 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Identity S, clear plaintext and monitors; ct_mem is set by the caller.
  task automatic prep();
    @(negedge clk);
    init_s = 1'b1;
    clr_mon = 1'b1;
    @(negedge clk);
    init_s = 1'b0;
    clr_mon = 1'b0;
  endtask

  task automatic run_to_done(input bit drop, output int cyc);
    bit dropped;
    dropped = 1'b0;
    @(negedge clk);
    sld = 1'b1;
    cyc = 0;
    while (!done_flag && cyc < 2000) begin
      @(posedge clk);
      #1;
      cyc++;
      if (drop && !dropped && dut.state_q == StWaitSj && pt_cnt >= 3) begin
        dropped = 1'b1;
        sld = 1'b0;
        repeat (10) begin
          @(posedge clk);
          #1;
          cyc++;
        end
        sld = 1'b1;
      end
    end
    check_eq("run_done", 32'(done_flag), 32'd1);
    if (drop) check_eq("drop_hit", 32'(dropped), 32'd1);
  endtask

  int cyc, n;

  initial begin
    for (int x = 0; x < 32; x++) ct_mem[x] = 8'h00;
    do_reset();
    #1;
    check_eq("rst_done", 32'(done_flag), 32'd0);
    check_eq("rst_swren", 32'(s_wren), 32'd0);
    check_eq("rst_ptwren", 32'(pt_wren), 32'd0);
    check_eq("rst_saddr", 32'(s_addr), 32'd0);
    check_eq("rst_swdata", 32'(s_wrdata), 32'd0);
    check_eq("rst_ctaddr", 32'(ct_addr), 32'd0);
    check_eq("rst_ptaddr", 32'(pt_addr), 32'd0);
    check_eq("rst_ptwdata", 32'(pt_wrdata), 32'd0);
`ifdef PLAINTEXT_CHECK_EN
    check_eq("rst_keyinv", 32'(key_invalid), 32'd0);

    // First byte 0x02 is rejected: no write, key_invalid and done at the end of byte 0.
    prep();
    run_to_done(1'b0, cyc);
    check_eq("inv_cycles", 32'(cyc), 32'd17);
    check_eq("inv_ptcnt", 32'(pt_cnt), 32'd0);
    check_eq("inv_keyinv", 32'(key_invalid), 32'd1);

    // 'a','e' accepted, third byte 0x07 rejected.
    do_reset();
    ct_mem[0] = 8'h63;
    ct_mem[1] = 8'h60;
    prep();
    run_to_done(1'b0, cyc);
    check_eq("ae_cycles", 32'(cyc), 32'd49);
    check_eq("ae_pt0", 32'(pt_mem[0]), 32'h61);
    check_eq("ae_pt1", 32'(pt_mem[1]), 32'h65);
    check_eq("ae_ptcnt", 32'(pt_cnt), 32'd2);
    check_eq("ae_keyinv", 32'(key_invalid), 32'd1);
`else
    // Full run, ct all zero.
    prep();
    model_run();
    run_to_done(1'b0, cyc);
    check_eq("t1_cycles", 32'(cyc), 32'd513);
    check_eq("t1_pt0", 32'(pt_mem[0]), 32'h02);
    check_eq("t1_pt1", 32'(pt_mem[1]), 32'h05);
    check_eq("t1_s2", 32'(cap2), 32'd3);
    check_eq("t1_s3", 32'(cap3), 32'd2);
    check_eq("t1_ptcnt", 32'(pt_cnt), 32'd32);
    for (int x = 0; x < 32; x++) check_eq($sformatf("t1_pt%0d", x), 32'(pt_mem[x]), 32'(exp_pt[x]));
    @(negedge clk);
    sld = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check_eq("t1_sticky", 32'(done_flag), 32'd1);
    check_eq("t1_done_saddr", 32'(s_addr), 32'd0);
    check_eq("t1_done_ptcnt", 32'(pt_cnt), 32'd32);

    // ASCII ciphertext.
    do_reset();
    ct_mem[0] = 8'h63;
    ct_mem[1] = 8'h60;
    prep();
    run_to_done(1'b0, cyc);
    check_eq("t2_pt0", 32'(pt_mem[0]), 32'h61);
    check_eq("t2_pt1", 32'(pt_mem[1]), 32'h65);
    ct_mem[0] = 8'h00;
    ct_mem[1] = 8'h00;

    // Reset during WRITE_I of byte 5 (the 11th S write).
    do_reset();
    prep();
    @(negedge clk);
    sld = 1'b1;
    n = 0;
    cyc = 0;
    while (n < 11 && cyc < 400) begin
      @(posedge clk);
      #1;
      cyc++;
      if (s_wren) n++;
    end
    check_eq("t3_hit", 32'(n), 32'd11);
    check_eq("t3_wi_addr", 32'(s_addr), 32'd6);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("t3_swren", 32'(s_wren), 32'd0);
    check_eq("t3_ptwren", 32'(pt_wren), 32'd0);
    check_eq("t3_done", 32'(done_flag), 32'd0);
    check_eq("t3_state", 32'(dut.state_q), 32'(StIdle));
    sld = 1'b0;
    prep();
    @(negedge clk);
    rst = 1'b0;
    run_to_done(1'b0, cyc);
    check_eq("t3_cycles", 32'(cyc), 32'd513);
    check_eq("t3_pt0", 32'(pt_mem[0]), 32'h02);

    // Start level dropped for 10 cycles while waiting on the S[j] read.
    do_reset();
    prep();
    model_run();
    run_to_done(1'b1, cyc);
    check_eq("t4_cycles", 32'(cyc), 32'd523);
    check_eq("t4_gapwr", 32'(gap_wr), 32'd0);
    check_eq("t4_ptcnt", 32'(pt_cnt), 32'd32);
    for (int x = 0; x < 32; x++) check_eq($sformatf("t4_pt%0d", x), 32'(pt_mem[x]), 32'(exp_pt[x]));

    // MSG_LEN=1 instance.
    do_reset();
    prep();
    @(negedge clk);
    sld1 = 1'b1;
    cyc = 0;
    while (!done1 && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check_eq("t5_cycles", 32'(cyc), 32'd17);
    check_eq("t5_ptcnt", 32'(pt_cnt1), 32'd1);
    check_eq("t5_pt0", 32'(pt_last1), 32'h02);
    check_eq("t5_addr", 32'(pt_addr_last1), 32'd0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
